// File: rtl/pcie_pkg.sv
// Shared FSM encoding and field-position helpers for the PCIe VC router.
package pcie_pkg;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_INIT,
    ST_IDLE,
    ST_ACTIVE,
    ST_ERROR
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // The VC id occupies the top bits of a word; the dest id sits just below it.
  function automatic int vc_lsb(input int data_w, input int num_vc);
    return data_w - clog2(num_vc);
  endfunction

  function automatic int dest_lsb(input int data_w, input int num_vc, input int num_dest);
    return vc_lsb(data_w, num_vc) - clog2(num_dest);
  endfunction

endpackage

// File: rtl/pcie_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and a programmable almost-full threshold.
module pcie_sync_fifo
  import pcie_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  input  logic [AW:0]       threshold,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic              almost_full
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full        = (count == DEPTH_CNT);
  assign empty       = (count == '0);
  assign almost_full = (count >= threshold);
  assign rdata       = mem[rd_ptr];
  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;

  // Pointers are exactly AW bits wide so they wrap modulo the depth on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pcie_vc_router.sv
// PCIe transaction-layer router: ingress FIFO -> per-VC FIFOs -> VC arbiter -> per-dest FIFOs.
// Build option ARB_RR_EN selects a round-robin VC arbiter instead of strict lowest-index priority.
module pcie_vc_router
  import pcie_pkg::*;
#(
  parameter int DATA_W   = 6,
  parameter int NUM_VC   = 2,
  parameter int NUM_DEST = 2,
  parameter int MF_AW    = 2,
  parameter int VC_AW    = 4,
  parameter int D_AW     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [MF_AW:0]             umbral_mf,
  input  logic [VC_AW:0]             umbral_vc,
  input  logic [D_AW:0]              umbral_d,
  input  logic                       push,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       pause_out,
  input  logic [NUM_DEST-1:0]        pop_d,
  output logic [NUM_DEST*DATA_W-1:0] data_out,
  output logic [NUM_DEST-1:0]        valid_out,
  output logic [NUM_DEST-1:0]        empty_d,
  output logic                       active_out,
  output logic                       idle_out,
  output logic                       error_out
);

  localparam int VC_BITS   = clog2(NUM_VC);
  localparam int DEST_BITS = clog2(NUM_DEST);
  localparam int VC_LSB    = vc_lsb(DATA_W, NUM_VC);
  localparam int DEST_LSB  = dest_lsb(DATA_W, NUM_VC, NUM_DEST);
  localparam logic [MF_AW:0] MF_DEPTH = (MF_AW + 1)'(1 << MF_AW);
  localparam logic [VC_AW:0] VC_DEPTH = (VC_AW + 1)'(1 << VC_AW);
  localparam logic [D_AW:0]  D_DEPTH  = (D_AW + 1)'(1 << D_AW);

  state_t state, state_nxt;
  logic [MF_AW:0] thr_mf;
  logic [VC_AW:0] thr_vc;
  logic [D_AW:0]  thr_d;
  logic           run;
  logic           busy;
  logic           err_event;

  logic [DATA_W-1:0]  mf_rdata;
  logic               mf_full, mf_empty, mf_af, mf_pop;
  logic [VC_BITS-1:0] mf_vc;

  logic [DATA_W-1:0]  vc_rdata [NUM_VC];
  logic [NUM_VC-1:0]  vc_push, vc_pop, vc_full, vc_empty, vc_af, vc_elig;

  logic [DATA_W-1:0]   d_rdata [NUM_DEST];
  logic [NUM_DEST-1:0] d_push, d_pop, d_full, d_af;

  logic                 gnt_valid;
  logic [VC_BITS-1:0]   gnt_vc;
  logic [DATA_W-1:0]    gnt_word;
  logic [DEST_BITS-1:0] gnt_dest;

  // Stages B and C only move data once configuration is finished.
  assign run = (state == ST_IDLE) || (state == ST_ACTIVE) || (state == ST_ERROR);

  always_ff @(posedge clk) begin
    if (reset) begin
      thr_mf <= MF_DEPTH;
      thr_vc <= VC_DEPTH;
      thr_d  <= D_DEPTH;
    end else if (state == ST_INIT) begin
      thr_mf <= umbral_mf;
      thr_vc <= umbral_vc;
      thr_d  <= umbral_d;
    end
  end

  pcie_sync_fifo #(.DATA_W(DATA_W), .AW(MF_AW)) u_main (
    .clk(clk), .reset(reset), .push(push), .wdata(data_in), .pop(mf_pop),
    .threshold(thr_mf), .rdata(mf_rdata), .full(mf_full), .empty(mf_empty),
    .almost_full(mf_af)
  );

  assign pause_out = mf_af;
  assign mf_vc     = mf_rdata[VC_LSB +: VC_BITS];
  assign mf_pop    = run && !mf_empty && !vc_af[mf_vc] && !vc_full[mf_vc];

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    logic [DEST_BITS-1:0] head_dest;

    assign vc_push[i] = mf_pop && (mf_vc == VC_BITS'(i));
    assign vc_pop[i]  = gnt_valid && (gnt_vc == VC_BITS'(i));
    assign head_dest  = vc_rdata[i][DEST_LSB +: DEST_BITS];
    assign vc_elig[i] = run && !vc_empty[i] && !d_af[head_dest] && !d_full[head_dest];

    pcie_sync_fifo #(.DATA_W(DATA_W), .AW(VC_AW)) u_vc (
      .clk(clk), .reset(reset), .push(vc_push[i]), .wdata(mf_rdata), .pop(vc_pop[i]),
      .threshold(thr_vc), .rdata(vc_rdata[i]), .full(vc_full[i]), .empty(vc_empty[i]),
      .almost_full(vc_af[i])
    );
  end

`ifdef ARB_RR_EN
  logic [VC_BITS-1:0] rr_ptr;
  logic [VC_BITS-1:0] cand;

  // Search starts one past the last granted VC; the VC_BITS-wide sum wraps modulo NUM_VC.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_vc    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_VC; k++) begin
      cand = rr_ptr + VC_BITS'(k);
      if (!gnt_valid && vc_elig[cand]) begin
        gnt_valid = 1'b1;
        gnt_vc    = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          rr_ptr <= VC_BITS'(NUM_VC - 1);
    else if (gnt_valid) rr_ptr <= gnt_vc;
  end
`else
  always_comb begin
    gnt_valid = 1'b0;
    gnt_vc    = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      if (!gnt_valid && vc_elig[k]) begin
        gnt_valid = 1'b1;
        gnt_vc    = VC_BITS'(k);
      end
    end
  end
`endif

  assign gnt_word = vc_rdata[gnt_vc];
  assign gnt_dest = gnt_word[DEST_LSB +: DEST_BITS];

  for (genvar k = 0; k < NUM_DEST; k++) begin : g_dest
    assign d_push[k] = gnt_valid && (gnt_dest == DEST_BITS'(k));
    assign d_pop[k]  = pop_d[k] && !empty_d[k];

    pcie_sync_fifo #(.DATA_W(DATA_W), .AW(D_AW)) u_dest (
      .clk(clk), .reset(reset), .push(d_push[k]), .wdata(gnt_word), .pop(d_pop[k]),
      .threshold(thr_d), .rdata(d_rdata[k]), .full(d_full[k]), .empty(empty_d[k]),
      .almost_full(d_af[k])
    );
  end

  // Egress register: data holds its last value when no pop is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= '0;
    end else begin
      for (int k = 0; k < NUM_DEST; k++) begin
        valid_out[k] <= d_pop[k];
        if (d_pop[k]) data_out[k*DATA_W +: DATA_W] <= d_rdata[k];
      end
    end
  end

  assign err_event = (push && mf_full) || (|(pop_d & empty_d));
  assign busy      = !mf_empty || !(&vc_empty) || !(&empty_d);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RESET;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET:  state_nxt = ST_INIT;
      ST_INIT: begin
        if (err_event)  state_nxt = ST_ERROR;
        else if (!init) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (err_event) state_nxt = ST_ERROR;
        else if (init) state_nxt = ST_INIT;
        else if (busy) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (err_event)  state_nxt = ST_ERROR;
        else if (init)  state_nxt = ST_INIT;
        else if (!busy) state_nxt = ST_IDLE;
      end
      ST_ERROR:  state_nxt = ST_ERROR;
      default:   state_nxt = ST_RESET;
    endcase
  end

  assign active_out = (state == ST_ACTIVE);
  assign idle_out   = (state == ST_IDLE);
  assign error_out  = (state == ST_ERROR);

endmodule

// File: tb/tb_pcie_vc_router.sv
// Self-checking bench for pcie_vc_router: directed scenarios plus randomized traffic
// checked against a per-(VC,dest) ordering scoreboard.
module tb_pcie_vc_router;

  localparam int DATA_W   = 6;
  localparam int NUM_VC   = 2;
  localparam int NUM_DEST = 2;
  localparam int MF_AW    = 2;
  localparam int VC_AW    = 4;
  localparam int D_AW     = 2;
  localparam int VC_BIT   = DATA_W - 1;
  localparam int DEST_BIT = DATA_W - 2;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       init;
  logic [MF_AW:0]             umbral_mf;
  logic [VC_AW:0]             umbral_vc;
  logic [D_AW:0]              umbral_d;
  logic                       push;
  logic [DATA_W-1:0]          data_in;
  logic                       pause_out;
  logic [NUM_DEST-1:0]        pop_d;
  logic [NUM_DEST*DATA_W-1:0] data_out;
  logic [NUM_DEST-1:0]        valid_out;
  logic [NUM_DEST-1:0]        empty_d;
  logic                       active_out;
  logic                       idle_out;
  logic                       error_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] got_q [$];
  logic [DATA_W-1:0] sb [NUM_VC*NUM_DEST][$];

  pcie_vc_router #(
    .DATA_W(DATA_W), .NUM_VC(NUM_VC), .NUM_DEST(NUM_DEST),
    .MF_AW(MF_AW), .VC_AW(VC_AW), .D_AW(D_AW)
  ) dut (
    .clk(clk), .reset(reset), .init(init), .umbral_mf(umbral_mf), .umbral_vc(umbral_vc),
    .umbral_d(umbral_d), .push(push), .data_in(data_in), .pause_out(pause_out),
    .pop_d(pop_d), .data_out(data_out), .valid_out(valid_out), .empty_d(empty_d),
    .active_out(active_out), .idle_out(idle_out), .error_out(error_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] dout(input int k);
    return data_out[k*DATA_W +: DATA_W];
  endfunction

  task automatic do_reset(input logic [MF_AW:0] mf, input logic [VC_AW:0] vc, input logic [D_AW:0] d);
    reset = 1'b1; init = 1'b0; push = 1'b0; pop_d = '0; data_in = '0;
    umbral_mf = mf; umbral_vc = vc; umbral_d = d;
    tick(); tick();
    reset = 1'b0; init = 1'b1;
    tick(); tick();
    init = 1'b0;
    tick();
  endtask

  // Pops dest k every cycle until it reports empty, collecting the words returned.
  task automatic drain(input int k, input int max_n);
    got_q.delete();
    for (int i = 0; i < max_n && empty_d[k] === 1'b0; i++) begin
      pop_d[k] = 1'b1;
      tick();
      pop_d[k] = 1'b0;
      if (valid_out[k] === 1'b1) got_q.push_back(dout(k));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; init = 1'b0; push = 1'b0; pop_d = '0; data_in = '0;
    umbral_mf = 3'd3; umbral_vc = 5'd8; umbral_d = 3'd2;
    tick(); tick();
    n_checks++;
    if (data_out !== '0) $display("[TB] FAIL reset_data_out: got %h expected 0", data_out);
    else n_pass++;
    n_checks++;
    if (valid_out !== 2'b00) $display("[TB] FAIL reset_valid_out: got %b expected 00", valid_out);
    else n_pass++;
    n_checks++;
    if (empty_d !== 2'b11) $display("[TB] FAIL reset_empty_d: got %b expected 11", empty_d);
    else n_pass++;
    n_checks++;
    if ({pause_out, active_out, idle_out, error_out} !== 4'b0000)
      $display("[TB] FAIL reset_flags: got %b expected 0000", {pause_out, active_out, idle_out, error_out});
    else n_pass++;
    reset = 1'b0; init = 1'b1;
    tick(); tick();
    n_checks++;
    if (idle_out !== 1'b0) $display("[TB] FAIL init_not_idle: got %b expected 0", idle_out);
    else n_pass++;
    init = 1'b0;
    tick();
    n_checks++;
    if ({idle_out, active_out} !== 2'b10) $display("[TB] FAIL init_to_idle: got %b expected 10", {idle_out, active_out});
    else n_pass++;
  endtask

  task automatic test_single_word();
    push = 1'b1; data_in = 6'h25;
    tick();
    push = 1'b0;
    n_checks++;
    if (empty_d[0] !== 1'b1) $display("[TB] FAIL lat_t0_empty: got %b expected 1", empty_d[0]);
    else n_pass++;
    tick();
    n_checks++;
    if (empty_d[0] !== 1'b1) $display("[TB] FAIL lat_t1_empty: got %b expected 1", empty_d[0]);
    else n_pass++;
    n_checks++;
    if (active_out !== 1'b1) $display("[TB] FAIL single_active: got %b expected 1", active_out);
    else n_pass++;
    tick();
    n_checks++;
    if (empty_d !== 2'b10) $display("[TB] FAIL lat_t2_empty: got %b expected 10", empty_d);
    else n_pass++;
    pop_d[0] = 1'b1;
    tick();
    pop_d[0] = 1'b0;
    n_checks++;
    if (valid_out !== 2'b01 || dout(0) !== 6'h25)
      $display("[TB] FAIL single_pop: got valid=%b data=%h expected valid=01 data=25", valid_out, dout(0));
    else n_pass++;
    tick();
    n_checks++;
    if (valid_out !== 2'b00 || dout(0) !== 6'h25)
      $display("[TB] FAIL single_hold: got valid=%b data=%h expected valid=00 data=25", valid_out, dout(0));
    else n_pass++;
    n_checks++;
    if (idle_out !== 1'b1) $display("[TB] FAIL single_idle: got %b expected 1", idle_out);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < 6; i++) begin
      push = 1'b1; data_in = DATA_W'(8'h10 + i);
      tick();
    end
    push = 1'b0;
    repeat (6) tick();
    init = 1'b1;
    tick(); tick();
    drain(1, 8);
    n_checks++;
    if (got_q.size() !== 2) $display("[TB] FAIL bp_first_count: got %0d expected 2", got_q.size());
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      w = (got_q.size() > i) ? got_q[i] : 'x;
      n_checks++;
      if (w !== DATA_W'(8'h10 + i)) $display("[TB] FAIL bp_first_word%0d: got %h expected %h", i, w, 8'h10 + i);
      else n_pass++;
    end
    init = 1'b0;
    repeat (5) tick();
    pop_d[1] = 1'b1;
    tick();
    pop_d[1] = 1'b0;
    n_checks++;
    if (valid_out[1] !== 1'b1 || dout(1) !== 6'h12)
      $display("[TB] FAIL bp_single_pop: got valid=%b data=%h expected valid=1 data=12", valid_out[1], dout(1));
    else n_pass++;
    repeat (3) tick();
    init = 1'b1;
    tick(); tick();
    drain(1, 8);
    n_checks++;
    if (got_q.size() !== 2) $display("[TB] FAIL bp_refill_count: got %0d expected 2", got_q.size());
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      w = (got_q.size() > i) ? got_q[i] : 'x;
      n_checks++;
      if (w !== DATA_W'(8'h13 + i)) $display("[TB] FAIL bp_refill_word%0d: got %h expected %h", i, w, 8'h13 + i);
      else n_pass++;
    end
    init = 1'b0;
    repeat (5) tick();
    drain(1, 8);
    w = (got_q.size() > 0) ? got_q[0] : 'x;
    n_checks++;
    if (got_q.size() !== 1 || w !== 6'h15)
      $display("[TB] FAIL bp_last: got count=%0d word=%h expected count=1 word=15", got_q.size(), w);
    else n_pass++;
    repeat (2) tick();
    n_checks++;
    if (idle_out !== 1'b1) $display("[TB] FAIL bp_idle: got %b expected 1", idle_out);
    else n_pass++;
  endtask

  task automatic test_overflow();
    umbral_vc = '0; init = 1'b1;
    tick(); tick();
    init = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; data_in = DATA_W'(8'h20 + i);
      tick();
      n_checks++;
      if (pause_out !== ((i + 1) >= 3)) $display("[TB] FAIL ovf_pause%0d: got %b expected %b", i, pause_out, (i + 1) >= 3);
      else n_pass++;
    end
    push = 1'b0;
    n_checks++;
    if (error_out !== 1'b0) $display("[TB] FAIL ovf_no_err_yet: got %b expected 0", error_out);
    else n_pass++;
    push = 1'b1; data_in = 6'h3f;
    tick();
    push = 1'b0;
    n_checks++;
    if (error_out !== 1'b1) $display("[TB] FAIL ovf_error: got %b expected 1", error_out);
    else n_pass++;
    repeat (4) tick();
    n_checks++;
    if ({error_out, active_out, idle_out} !== 3'b100)
      $display("[TB] FAIL ovf_sticky: got %b expected 100", {error_out, active_out, idle_out});
    else n_pass++;
  endtask

  task automatic test_arbitration();
    logic [DATA_W-1:0] words [6];
    logic [DATA_W-1:0] expect_q [$];
    logic [DATA_W-1:0] w;
    words = '{6'h01, 6'h31, 6'h02, 6'h32, 6'h03, 6'h33};
`ifdef ARB_RR_EN
    expect_q = '{6'h01, 6'h31, 6'h02, 6'h32, 6'h03, 6'h33};
`else
    expect_q = '{6'h01, 6'h02, 6'h03, 6'h31, 6'h32, 6'h33};
`endif
    do_reset(3'd3, 5'd8, 3'd0);
    for (int i = 0; i < 6; i++) begin
      push = 1'b1; data_in = words[i];
      tick();
    end
    push = 1'b0;
    repeat (4) tick();
    n_checks++;
    if ({empty_d, error_out} !== 3'b110)
      $display("[TB] FAIL arb_thr0_stall: got empty/err=%b expected 110", {empty_d, error_out});
    else n_pass++;
    umbral_d = 3'd4; init = 1'b1;
    tick(); tick();
    init = 1'b0;
    tick();
    got_q.delete();
    for (int c = 0; c < 16; c++) begin
      pop_d = ~empty_d;
      tick();
      pop_d = '0;
      for (int k = 0; k < NUM_DEST; k++)
        if (valid_out[k] === 1'b1) got_q.push_back(dout(k));
    end
    n_checks++;
    if (got_q.size() !== 6) $display("[TB] FAIL arb_count: got %0d expected 6", got_q.size());
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      w = (got_q.size() > i) ? got_q[i] : 'x;
      n_checks++;
      if (w !== expect_q[i]) $display("[TB] FAIL arb_order%0d: got %h expected %h", i, w, expect_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_error_reset();
    n_checks++;
    if ({empty_d[0], error_out} !== 2'b10) $display("[TB] FAIL err_pre: got %b expected 10", {empty_d[0], error_out});
    else n_pass++;
    pop_d[0] = 1'b1;
    tick();
    pop_d[0] = 1'b0;
    n_checks++;
    if ({valid_out[0], error_out} !== 2'b01)
      $display("[TB] FAIL err_empty_pop: got valid/err=%b expected 01", {valid_out[0], error_out});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; data_in = DATA_W'(8'h05 + i);
      tick();
    end
    push = 1'b0;
    reset = 1'b1;
    tick();
    n_checks++;
    if ({empty_d, valid_out, error_out, pause_out} !== 6'b110000 || dout(0) !== '0)
      $display("[TB] FAIL rst_mid: got empty=%b valid=%b err=%b pause=%b data=%h expected 11 00 0 0 00",
               empty_d, valid_out, error_out, pause_out, dout(0));
    else n_pass++;
    reset = 1'b0; init = 1'b1;
    tick(); tick();
    init = 1'b0;
    repeat (5) tick();
    n_checks++;
    if ({empty_d, idle_out} !== 3'b111) $display("[TB] FAIL rst_clean: got %b expected 111", {empty_d, idle_out});
    else n_pass++;
  endtask

  task automatic test_random_traffic();
    logic [NUM_DEST-1:0] prev_pop;
    logic [DATA_W-1:0]   w;
    int                  idx;
    int                  leftover;
    do_reset(3'd3, 5'd8, 3'd2);
    for (int q = 0; q < NUM_VC * NUM_DEST; q++) sb[q].delete();
    for (int cyc = 0; cyc < 460; cyc++) begin
      pop_d = NUM_DEST'($urandom) & ~empty_d;
      if (cyc >= 400) pop_d = ~empty_d;
      push = (cyc < 300) && !pause_out && ($urandom_range(0, 2) != 0);
      data_in = DATA_W'($urandom);
      if (push) sb[int'(data_in[VC_BIT]) * NUM_DEST + int'(data_in[DEST_BIT])].push_back(data_in);
      prev_pop = pop_d;
      tick();
      push = 1'b0;
      pop_d = '0;
      for (int k = 0; k < NUM_DEST; k++) begin
        n_checks++;
        if (valid_out[k] !== prev_pop[k])
          $display("[TB] FAIL rnd_valid cyc%0d dest%0d: got %b expected %b", cyc, k, valid_out[k], prev_pop[k]);
        else n_pass++;
        if (valid_out[k] === 1'b1) begin
          w = dout(k);
          idx = int'(w[VC_BIT]) * NUM_DEST + k;
          n_checks++;
          if (w[DEST_BIT] !== 1'(k) || sb[idx].size() == 0 || w !== sb[idx][0])
            $display("[TB] FAIL rnd_data cyc%0d dest%0d: got %h expected %h", cyc, k, w,
                     (sb[idx].size() > 0) ? sb[idx][0] : 6'h00);
          else n_pass++;
          if (sb[idx].size() > 0 && w === sb[idx][0]) void'(sb[idx].pop_front());
        end
      end
    end
    leftover = 0;
    for (int q = 0; q < NUM_VC * NUM_DEST; q++) leftover += sb[q].size();
    n_checks++;
    if (leftover !== 0) $display("[TB] FAIL rnd_undelivered: got %0d words left expected 0", leftover);
    else n_pass++;
    n_checks++;
    if ({error_out, empty_d} !== 3'b011) $display("[TB] FAIL rnd_final: got err/empty=%b expected 011", {error_out, empty_d});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_overflow();
    test_arbitration();
    test_error_reset();
    test_random_traffic();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
